// File: rtl/gci_std_display_vram_responder.sv
// VRAM-side responder: arbitration grant, command acceptance, SRAM drive and
// in-order read return through a credit-limited FIFO with requester backpressure.
module gci_std_display_vram_responder #(
   parameter int P_MEM_ADDR_N      = 19,
   parameter int P_SRAM_RD_LATENCY = 1,
   parameter int P_FIFO_DEPTH      = 4
) (
   input  logic                    iCLOCK,
   input  logic                    inRESET,
   input  logic                    iRESET_SYNC,
   input  logic                    iARBIT_REQ,
   output logic                    oARBIT_ACK,
   input  logic                    iARBIT_FINISH,
   input  logic                    iENA,
   output logic                    oBUSY,
   input  logic                    iRW,
   input  logic [P_MEM_ADDR_N-1:0] iADDR,
   input  logic [31:0]             iDATA,
   output logic                    oVALID,
   input  logic                    iBUSY,
   output logic [31:0]             oDATA,
   output logic                    oSRAM_CE,
   output logic                    oSRAM_WE,
   output logic [P_MEM_ADDR_N-1:0] oSRAM_ADDR,
   output logic [31:0]             oSRAM_DATA,
   input  logic [31:0]             iSRAM_DATA
);

   localparam int PW = $clog2(P_FIFO_DEPTH);
   localparam int CW = $clog2(P_FIFO_DEPTH + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(P_FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      WORK  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t                    state_r;
   logic                      ack_r;
   logic [CW-1:0]             outstanding_r;
   logic                      sram_ce_r;
   logic                      sram_we_r;
   logic [P_MEM_ADDR_N-1:0]   sram_addr_r;
   logic [31:0]               sram_data_r;
   logic [P_SRAM_RD_LATENCY-1:0] tag_r;
   logic [PW:0]               wr_ptr_r;
   logic [PW:0]               rd_ptr_r;
   logic [31:0]               fifo_mem_r [P_FIFO_DEPTH];

   logic busy_s;
   logic accept_s;
   logic rd_accept_s;
   logic push_s;
   logic pop_s;
   logic empty_s;

   // Outstanding counts reads from acceptance until pop, so it doubles as the credit counter.
   assign empty_s     = (wr_ptr_r == rd_ptr_r);
   assign busy_s      = (state_r != WORK) || (outstanding_r == FULL_CNT);
   assign accept_s    = iENA && !busy_s;
   assign rd_accept_s = accept_s && !iRW;
   assign push_s      = tag_r[P_SRAM_RD_LATENCY-1];
   assign pop_s       = !empty_s && !iBUSY;

   assign oARBIT_ACK = ack_r;
   assign oBUSY      = busy_s;
   assign oVALID     = pop_s;
   assign oDATA      = empty_s ? 32'h0000_0000 : fifo_mem_r[rd_ptr_r[PW-1:0]];
   assign oSRAM_CE   = sram_ce_r;
   assign oSRAM_WE   = sram_we_r;
   assign oSRAM_ADDR = sram_addr_r;
   assign oSRAM_DATA = sram_data_r;

   // Ownership FSM with the registered grant pulse.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         state_r <= IDLE;
         ack_r   <= 1'b0;
      end else if (iRESET_SYNC) begin
         state_r <= IDLE;
         ack_r   <= 1'b0;
      end else begin
         ack_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (iARBIT_REQ) begin
                  state_r <= GRANT;
                  ack_r   <= 1'b1;
               end
            end
            GRANT: state_r <= WORK;
            WORK: begin
               if (iARBIT_FINISH) begin
                  state_r <= DRAIN;
               end
            end
            DRAIN: begin
               if (outstanding_r == {CW{1'b0}}) begin
                  state_r <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // SRAM command register, read-tag pipeline, FIFO pointers and credit counter.
   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         sram_ce_r     <= 1'b0;
         sram_we_r     <= 1'b0;
         sram_addr_r   <= {P_MEM_ADDR_N{1'b0}};
         sram_data_r   <= 32'h0000_0000;
         tag_r         <= {P_SRAM_RD_LATENCY{1'b0}};
         wr_ptr_r      <= {(PW + 1){1'b0}};
         rd_ptr_r      <= {(PW + 1){1'b0}};
         outstanding_r <= {CW{1'b0}};
      end else if (iRESET_SYNC) begin
         sram_ce_r     <= 1'b0;
         sram_we_r     <= 1'b0;
         sram_addr_r   <= {P_MEM_ADDR_N{1'b0}};
         sram_data_r   <= 32'h0000_0000;
         tag_r         <= {P_SRAM_RD_LATENCY{1'b0}};
         wr_ptr_r      <= {(PW + 1){1'b0}};
         rd_ptr_r      <= {(PW + 1){1'b0}};
         outstanding_r <= {CW{1'b0}};
      end else begin
         if (accept_s) begin
            sram_ce_r   <= 1'b1;
            sram_we_r   <= iRW;
            sram_addr_r <= iADDR;
            sram_data_r <= iRW ? iDATA : 32'h0000_0000;
         end else begin
            sram_ce_r   <= 1'b0;
            sram_we_r   <= 1'b0;
            sram_addr_r <= {P_MEM_ADDR_N{1'b0}};
            sram_data_r <= 32'h0000_0000;
         end
         tag_r[0] <= sram_ce_r && !sram_we_r;
         for (int i = 1; i < P_SRAM_RD_LATENCY; i++) begin
            tag_r[i] <= tag_r[i-1];
         end
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({rd_accept_s, pop_s})
            2'b10:   outstanding_r <= outstanding_r + CNT_ONE;
            2'b01:   outstanding_r <= outstanding_r - CNT_ONE;
            default: outstanding_r <= outstanding_r;
         endcase
      end
   end

   // Return FIFO storage; contents behind the pointers need no reset.
   always_ff @(posedge iCLOCK) begin
      if (push_s) begin
         fifo_mem_r[wr_ptr_r[PW-1:0]] <= iSRAM_DATA;
      end
   end

endmodule

// File: tb/tb_gci_std_display_vram_responder.sv
// Bench for gci_std_display_vram_responder: vector table, corner-case sequences
// and a randomized phase checked against a queue-based reference model.
module tb_gci_std_display_vram_responder;

   logic        iCLOCK = 1'b0;
   logic        inRESET, iRESET_SYNC, iARBIT_REQ, iARBIT_FINISH, iENA, iRW, iBUSY;
   logic [18:0] iADDR;
   logic [31:0] iDATA, iSRAM_DATA;
   logic        oARBIT_ACK, oBUSY, oVALID, oSRAM_CE, oSRAM_WE;
   logic [31:0] oDATA, oSRAM_DATA;
   logic [18:0] oSRAM_ADDR;

   always #5 iCLOCK = ~iCLOCK;

   gci_std_display_vram_responder dut (
      .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
      .iARBIT_REQ(iARBIT_REQ), .oARBIT_ACK(oARBIT_ACK), .iARBIT_FINISH(iARBIT_FINISH),
      .iENA(iENA), .oBUSY(oBUSY), .iRW(iRW), .iADDR(iADDR), .iDATA(iDATA),
      .oVALID(oVALID), .iBUSY(iBUSY), .oDATA(oDATA),
      .oSRAM_CE(oSRAM_CE), .oSRAM_WE(oSRAM_WE), .oSRAM_ADDR(oSRAM_ADDR),
      .oSRAM_DATA(oSRAM_DATA), .iSRAM_DATA(iSRAM_DATA)
   );

   // Synchronous SRAM with one cycle of read latency, 64 words.
   logic [31:0] sram [64];
   always @(posedge iCLOCK) begin
      if (oSRAM_CE) begin
         if (oSRAM_WE) sram[oSRAM_ADDR[5:0]] <= oSRAM_DATA;
         else          iSRAM_DATA <= sram[oSRAM_ADDR[5:0]];
      end
   end

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLOCK);
      #1;
      cyc++;
   endtask

   task automatic quiet();
      iARBIT_REQ = 1'b0; iARBIT_FINISH = 1'b0; iENA = 1'b0; iRW = 1'b0;
      iADDR = 19'h0; iDATA = 32'h0; iBUSY = 1'b0; iRESET_SYNC = 1'b0;
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, " ack"},   32'(oARBIT_ACK), 32'h0);
      chk({tag, " busy"},  32'(oBUSY),      32'h1);
      chk({tag, " valid"}, 32'(oVALID),     32'h0);
      chk({tag, " data"},  oDATA,           32'h0);
      chk({tag, " ce"},    32'(oSRAM_CE),   32'h0);
      chk({tag, " we"},    32'(oSRAM_WE),   32'h0);
      chk({tag, " addr"},  32'(oSRAM_ADDR), 32'h0);
      chk({tag, " sdata"}, oSRAM_DATA,      32'h0);
   endtask

   typedef struct {
      logic req, fin, ena, rw; logic [18:0] addr; logic [31:0] data; logic ibusy;
      logic ack, busy, ce, we; logic [18:0] sa; logic valid; logic [31:0] odata;
   } vec_t;

   typedef struct { logic [31:0] data; int ready; } exp_t;

   vec_t        tbl [12];
   exp_t        q [$];
   logic [31:0] refmem [64];
   logic [31:0] got [$];

   initial begin
      int k, nv, nack, nvalid;
      logic acc, seen_ack, exp_busy, exp_valid;

      tbl[0]  = '{1'b1,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b1,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[1]  = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b1,1'b1,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[2]  = '{1'b0,1'b0,1'b1,1'b1,19'h10,32'hA5A5_0001,1'b0, 1'b0,1'b0,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[3]  = '{1'b0,1'b0,1'b1,1'b0,19'h10,32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b1,19'h10,1'b0,32'h0};
      tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b0,1'b1,1'b0,19'h10,1'b0,32'h0};
      tbl[5]  = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[6]  = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b0,19'h0, 1'b1,32'hA5A5_0001};
      tbl[7]  = '{1'b0,1'b1,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[8]  = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b1,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b1,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[10] = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b1,1'b1,1'b0,1'b0,19'h0, 1'b0,32'h0};
      tbl[11] = '{1'b0,1'b0,1'b0,1'b0,19'h0, 32'h0,        1'b0, 1'b0,1'b0,1'b0,1'b0,19'h0, 1'b0,32'h0};

      for (int i = 0; i < 64; i++) begin
         sram[i] = 32'h0;
         refmem[i] = 32'h0;
      end
      iSRAM_DATA = 32'h0;
      quiet();
      inRESET = 1'b0;
      tick(); tick();
      #4 chk_reset_outs("por");
      tick();
      inRESET = 1'b1;

      // Grant, write, read-back, release and re-grant, cycle by cycle.
      for (int i = 0; i < 12; i++) begin
         iARBIT_REQ = tbl[i].req; iARBIT_FINISH = tbl[i].fin; iENA = tbl[i].ena;
         iRW = tbl[i].rw; iADDR = tbl[i].addr; iDATA = tbl[i].data; iBUSY = tbl[i].ibusy;
         #4;
         chk($sformatf("v%0d ack", i),   32'(oARBIT_ACK), 32'(tbl[i].ack));
         chk($sformatf("v%0d busy", i),  32'(oBUSY),      32'(tbl[i].busy));
         chk($sformatf("v%0d ce", i),    32'(oSRAM_CE),   32'(tbl[i].ce));
         chk($sformatf("v%0d valid", i), 32'(oVALID),     32'(tbl[i].valid));
         chk($sformatf("v%0d data", i),  oDATA,           tbl[i].odata);
         if (tbl[i].ce) begin
            chk($sformatf("v%0d we", i),   32'(oSRAM_WE),   32'(tbl[i].we));
            chk($sformatf("v%0d addr", i), 32'(oSRAM_ADDR), 32'(tbl[i].sa));
         end
         tick();
      end
      quiet();

      // Backpressure: fill addresses 0..5, then 6 reads against a stalled requester.
      for (int a = 0; a < 6; a++) begin
         iENA = 1'b1; iRW = 1'b1; iADDR = 19'(a); iDATA = 32'(a);
         tick();
      end
      iRW = 1'b0; iBUSY = 1'b1; k = 0; nvalid = 0;
      repeat (6) begin
         iENA = 1'b1; iADDR = 19'(k);
         #4;
         acc = !oBUSY;
         if (oVALID) nvalid++;
         tick();
         if (acc) k++;
      end
      iENA = 1'b0;
      #4;
      chk("bp accepted", 32'(k), 32'd4);
      chk("bp busy", 32'(oBUSY), 32'h1);
      chk("bp no valid", 32'(nvalid), 32'd0);
      tick();
      iBUSY = 1'b0;
      got.delete();
      for (int n = 0; n < 40 && got.size() < 6; n++) begin
         iENA = (k < 6); iADDR = 19'(k);
         #4;
         if (oVALID) got.push_back(oDATA);
         acc = iENA && !oBUSY;
         tick();
         if (acc) k++;
      end
      iENA = 1'b0;
      chk("bp all accepted", 32'(k), 32'd6);
      chk("bp returned", 32'(got.size()), 32'd6);
      for (int i = 0; i < 6 && i < got.size(); i++) chk($sformatf("bp order%0d", i), got[i], 32'(i));

      // FINISH with 3 reads held by backpressure: stay in DRAIN, withhold ACK.
      iBUSY = 1'b1;
      for (int j = 0; j < 3; j++) begin
         iENA = 1'b1; iRW = 1'b0; iADDR = 19'(j);
         tick();
      end
      iENA = 1'b0; iARBIT_FINISH = 1'b1; iARBIT_REQ = 1'b1;
      tick();
      iARBIT_FINISH = 1'b0;
      nack = 0; nvalid = 0;
      repeat (10) begin
         #4;
         if (oARBIT_ACK) nack++;
         if (oVALID) nvalid++;
         tick();
      end
      #4;
      chk("drain no ack", 32'(nack), 32'd0);
      chk("drain no valid", 32'(nvalid), 32'd0);
      chk("drain busy", 32'(oBUSY), 32'h1);
      tick();
      iBUSY = 1'b0; nv = 0; seen_ack = 1'b0;
      for (int n = 0; n < 30 && !seen_ack; n++) begin
         #4;
         if (oVALID) nv++;
         if (oARBIT_ACK) seen_ack = 1'b1;
         tick();
      end
      iARBIT_REQ = 1'b0;
      chk("drain ack", 32'(seen_ack), 32'h1);
      chk("drain valids", 32'(nv), 32'd3);

      // Synchronous reset with two reads in flight.
      for (int j = 0; j < 2; j++) begin
         iENA = 1'b1; iRW = 1'b0; iADDR = 19'(3 + j);
         tick();
      end
      iENA = 1'b0; iRESET_SYNC = 1'b1;
      tick();
      iRESET_SYNC = 1'b0;
      #4 chk_reset_outs("srst");
      nvalid = 0;
      repeat (6) begin
         tick(); #4;
         if (oVALID) nvalid++;
      end
      chk("srst no valid", 32'(nvalid), 32'd0);
      tick();

      // Asynchronous reset between edges with two reads in flight.
      iARBIT_REQ = 1'b1; tick(); iARBIT_REQ = 1'b0; tick();
      for (int j = 0; j < 2; j++) begin
         iENA = 1'b1; iRW = 1'b0; iADDR = 19'(j);
         tick();
      end
      iENA = 1'b0;
      #2 inRESET = 1'b0;
      #1 chk_reset_outs("arst");
      #2 inRESET = 1'b1;
      nvalid = 0;
      repeat (6) begin
         tick(); #4;
         if (oVALID) nvalid++;
      end
      chk("arst no valid", 32'(nvalid), 32'd0);
      tick();

      // Randomized traffic against the credit/latency/order model.
      refmem[16] = 32'hA5A5_0001;
      for (int a = 0; a < 6; a++) refmem[a] = 32'(a);
      iARBIT_REQ = 1'b1; tick(); iARBIT_REQ = 1'b0; tick();
      q.delete();
      for (int n = 0; n < 600; n++) begin
         if (n < 560) begin
            iENA  = 1'($urandom_range(0, 1));
            iRW   = ($urandom_range(0, 2) == 0);
            iADDR = 19'($urandom_range(0, 63));
            iDATA = $urandom;
            iBUSY = 1'($urandom_range(0, 1));
         end else begin
            iENA = 1'b0; iBUSY = 1'b0;
         end
         #4;
         exp_busy  = (q.size() == 4);
         exp_valid = (q.size() > 0) && !iBUSY;
         if (exp_valid) exp_valid = (q[0].ready <= cyc);
         chk($sformatf("rnd%0d busy", n), 32'(oBUSY), 32'(exp_busy));
         chk($sformatf("rnd%0d valid", n), 32'(oVALID), 32'(exp_valid));
         if (exp_valid) begin
            chk($sformatf("rnd%0d data", n), oDATA, q[0].data);
            void'(q.pop_front());
         end
         if (iENA && !exp_busy) begin
            if (iRW) refmem[iADDR[5:0]] = iDATA;
            else     q.push_back('{refmem[iADDR[5:0]], cyc + 3});
         end
         tick();
      end
      chk("rnd drained", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
